// File: rtl/leitor_letreiro_pkg.sv
// Shared definitions for the sign-lamp pattern receiver: states, step count,
// the fixed 10-step pattern and the step-advance helper.
`timescale 1ns/1ps
package leitor_letreiro_pkg;

  typedef enum logic [1:0] {
    BUSCA    = 2'd0,
    CONFIRMA = 2'd1,
    TRAVADO  = 2'd2
  } estado_t;

  localparam int N_PASSOS = 10;

  // Index 0 sits in the least significant slot; words are {bar, mosca, azul}.
  localparam logic [N_PASSOS-1:0][2:0] PADRAO = {
    3'b001, 3'b010, 3'b111, 3'b000, 3'b011,
    3'b100, 3'b111, 3'b110, 3'b100, 3'b000
  };

  function automatic logic [3:0] proximo_passo(input logic [3:0] p);
    return (p == 4'(N_PASSOS - 1)) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

// File: rtl/leitor_letreiro_if.sv
// Sample/status bundle between a sign word source (master) and the receiver (slave).
`timescale 1ns/1ps
interface leitor_letreiro_if #(
  parameter int CICLO_W = 8
);
  logic               habilita;
  logic [2:0]         palavras;
  logic               travado;
  logic [3:0]         passo;
  logic               erro;
  logic [CICLO_W-1:0] ciclos;
  logic [7:0]         erros;

  modport master (
    output habilita, palavras,
    input  travado, passo, erro, ciclos, erros
  );

  modport slave (
    input  habilita, palavras,
    output travado, passo, erro, ciclos, erros
  );
endinterface

// File: rtl/leitor_letreiro_tabela_padrao.sv
// Combinational lookup of the expected sign word for a pattern index.
`timescale 1ns/1ps
module tabela_padrao
  import leitor_letreiro_pkg::*;
(
  input  logic [3:0] indice,
  output logic [2:0] palavra
);

  always_comb begin
    palavra = 3'b000;
    if (indice < 4'(N_PASSOS))
      palavra = PADRAO[indice];
  end

endmodule

// File: rtl/leitor_letreiro.sv
// Sign pattern receiver: hunts for the 000->100 sync pair, confirms LOCK_STEPS
// further steps, then tracks the pattern. Error counter only with
// LEITOR_LETREIRO_CONTADOR_ERROS_EN defined.
`timescale 1ns/1ps
module leitor_letreiro
  import leitor_letreiro_pkg::*;
#(
  parameter int LOCK_STEPS = 2,
  parameter int CICLO_W    = 8
) (
  input logic              clock,
  input logic              reset,
  leitor_letreiro_if.slave bus
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_STEPS);

  estado_t            estado;
  logic [2:0]         prev;
  logic [3:0]         passo;
  logic [3:0]         conta;
  logic               erro;
  logic [CICLO_W-1:0] ciclos;

  logic [3:0] prox;
  logic [2:0] esperado;
  logic       bate;
  logic       erro_evento;

  tabela_padrao u_tabela (
    .indice  (prox),
    .palavra (esperado)
  );

  assign prox        = proximo_passo(passo);
  assign bate        = (bus.palavras == esperado);
  assign erro_evento = bus.habilita && (estado == TRAVADO) && !bate;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= BUSCA;
      prev   <= 3'b111;
      passo  <= 4'd0;
      conta  <= 4'd0;
      erro   <= 1'b0;
      ciclos <= '0;
    end else begin
      erro <= 1'b0;
      if (bus.habilita) begin
        // Every accepted word becomes prev, matching or not, so a bad 000
        // can still serve as the first half of the next sync pair.
        prev <= bus.palavras;
        case (estado)
          BUSCA: begin
            if (prev == PADRAO[0] && bus.palavras == PADRAO[1]) begin
              estado <= CONFIRMA;
              passo  <= 4'd1;
              conta  <= 4'd0;
            end
          end
          CONFIRMA: begin
            if (bate) begin
              passo <= prox;
              conta <= conta + 4'd1;
              if (conta + 4'd1 == LOCK_N)
                estado <= TRAVADO;
            end else begin
              estado <= BUSCA;
              passo  <= 4'd0;
            end
          end
          TRAVADO: begin
            if (bate) begin
              passo <= prox;
              if (prox == 4'd0 && ciclos != {CICLO_W{1'b1}})
                ciclos <= ciclos + 1'b1;
            end else begin
              erro   <= 1'b1;
              estado <= BUSCA;
              passo  <= 4'd0;
            end
          end
          default: begin
            estado <= BUSCA;
            passo  <= 4'd0;
          end
        endcase
      end
    end
  end

`ifdef LEITOR_LETREIRO_CONTADOR_ERROS_EN
  logic [7:0] erros;

  always_ff @(posedge clock) begin
    if (reset)
      erros <= 8'd0;
    else if (erro_evento && erros != 8'hFF)
      erros <= erros + 8'd1;
  end

  assign bus.erros = erros;
`else
  assign bus.erros = 8'd0;
`endif

  assign bus.travado = (estado == TRAVADO);
  assign bus.passo   = passo;
  assign bus.erro    = erro;
  assign bus.ciclos  = ciclos;

endmodule

// File: tb/tb_leitor_letreiro.sv
// Directed self-checking bench for leitor_letreiro (LOCK_STEPS=2, CICLO_W=8).
`timescale 1ns/1ps
module tb_leitor_letreiro;

`ifdef LEITOR_LETREIRO_CONTADOR_ERROS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clock;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   pos;
  int   exp_ciclos;
  int   exp_erros;
  logic [2:0] pat [10];

  leitor_letreiro_if #(.CICLO_W(8)) bus ();

  leitor_letreiro #(.LOCK_STEPS(2), .CICLO_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic amostra(input logic h, input logic [2:0] w);
    @(negedge clock);
    reset = 1'b0;
    bus.habilita = h;
    bus.palavras = w;
    @(posedge clock);
    #1;
  endtask

  task automatic aplica_reset(input logic h, input logic [2:0] w);
    @(negedge clock);
    reset = 1'b1;
    bus.habilita = h;
    bus.palavras = w;
    @(posedge clock);
    #1;
  endtask

  function automatic int erros_mais_um(input int e);
    if (!CNT_EN) return 0;
    return (e < 255) ? e + 1 : 255;
  endfunction

  task automatic checa_reset_vals(input string nome);
    n_chk++;
    if (bus.travado !== 1'b0 || bus.passo !== 4'd0 || bus.erro !== 1'b0 ||
        bus.ciclos !== 8'd0 || bus.erros !== 8'd0) begin
      $display("FAIL %s: travado=%0b passo=%0d erro=%0b ciclos=%0d erros=%0d, required all 0",
               nome, bus.travado, bus.passo, bus.erro, bus.ciclos, bus.erros);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    aplica_reset(1'b0, 3'b000);
    checa_reset_vals("reset_values");
    // prev resets to 111, so an immediate 100 must not sync
    amostra(1'b1, 3'b100);
    n_chk++;
    if (bus.passo !== 4'd0) begin
      $display("FAIL reset_prev: passo=%0d required 0", bus.passo); n_fail++;
    end
  endtask

  task automatic test_lock();
    int erro_visto;
    erro_visto = 0;
    aplica_reset(1'b0, 3'b000);
    exp_ciclos = 0;
    exp_erros  = 0;
    for (int i = 0; i < 10; i++) begin
      amostra(1'b1, pat[i]);
      if (bus.erro) erro_visto++;
      if (i == 2) begin
        n_chk++;
        if (bus.travado !== 1'b0 || bus.passo !== 4'd2) begin
          $display("FAIL lock_confirm: travado=%0b passo=%0d required 0/2", bus.travado, bus.passo);
          n_fail++;
        end
      end
      if (i == 3) begin
        n_chk++;
        if (bus.travado !== 1'b1 || bus.passo !== 4'd3) begin
          $display("FAIL lock_rise: travado=%0b passo=%0d required 1/3", bus.travado, bus.passo);
          n_fail++;
        end
      end
    end
    n_chk++;
    if (bus.passo !== 4'd9 || bus.ciclos !== 8'd0) begin
      $display("FAIL lock_step9: passo=%0d ciclos=%0d required 9/0", bus.passo, bus.ciclos);
      n_fail++;
    end
    amostra(1'b1, pat[0]);
    exp_ciclos = 1;
    n_chk++;
    if (bus.passo !== 4'd0 || bus.ciclos !== 8'd1 || bus.travado !== 1'b1) begin
      $display("FAIL lock_cycle: passo=%0d ciclos=%0d travado=%0b required 0/1/1",
               bus.passo, bus.ciclos, bus.travado);
      n_fail++;
    end
    for (int i = 1; i <= 4; i++) begin
      amostra(1'b1, pat[i]);
      if (bus.erro) erro_visto++;
    end
    pos = 4;
    n_chk++;
    if (erro_visto != 0) begin
      $display("FAIL lock_no_erro: erro pulses=%0d required 0", erro_visto); n_fail++;
    end
  endtask

  task automatic test_mismatch();
    amostra(1'b1, 3'b101);
    exp_erros = erros_mais_um(exp_erros);
    n_chk++;
    if (bus.erro !== 1'b1 || bus.travado !== 1'b0 || bus.passo !== 4'd0 ||
        bus.erros !== 8'(exp_erros)) begin
      $display("FAIL mismatch: erro=%0b travado=%0b passo=%0d erros=%0d required 1/0/0/%0d",
               bus.erro, bus.travado, bus.passo, bus.erros, exp_erros);
      n_fail++;
    end
    amostra(1'b1, pat[6]);
    n_chk++;
    if (bus.erro !== 1'b0) begin
      $display("FAIL mismatch_pulse_len: erro=%0b required 0", bus.erro); n_fail++;
    end
    for (int i = 7; i <= 9; i++) amostra(1'b1, pat[i]);
    n_chk++;
    if (bus.travado !== 1'b0 || bus.passo !== 4'd0) begin
      $display("FAIL mismatch_hunt: travado=%0b passo=%0d required 0/0", bus.travado, bus.passo);
      n_fail++;
    end
    for (int i = 0; i <= 3; i++) amostra(1'b1, pat[i]);
    pos = 3;
    n_chk++;
    if (bus.travado !== 1'b1 || bus.passo !== 4'd3 || bus.ciclos !== 8'(exp_ciclos)) begin
      $display("FAIL mismatch_relock: travado=%0b passo=%0d ciclos=%0d required 1/3/%0d",
               bus.travado, bus.passo, bus.ciclos, exp_ciclos);
      n_fail++;
    end
  endtask

  task automatic test_hold_zeros();
    amostra(1'b1, 3'b000);
    exp_erros = erros_mais_um(exp_erros);
    n_chk++;
    if (bus.erro !== 1'b1 || bus.travado !== 1'b0 || bus.erros !== 8'(exp_erros)) begin
      $display("FAIL zeros_first: erro=%0b travado=%0b erros=%0d required 1/0/%0d",
               bus.erro, bus.travado, bus.erros, exp_erros);
      n_fail++;
    end
    for (int k = 0; k < 2; k++) begin
      amostra(1'b1, 3'b000);
      n_chk++;
      if (bus.erro !== 1'b0 || bus.passo !== 4'd0 || bus.erros !== 8'(exp_erros)) begin
        $display("FAIL zeros_hold%0d: erro=%0b passo=%0d erros=%0d required 0/0/%0d",
                 k, bus.erro, bus.passo, bus.erros, exp_erros);
        n_fail++;
      end
    end
    amostra(1'b1, 3'b100);
    n_chk++;
    if (bus.passo !== 4'd1 || bus.travado !== 1'b0) begin
      $display("FAIL zeros_sync: passo=%0d travado=%0b required 1/0", bus.passo, bus.travado);
      n_fail++;
    end
    for (int i = 2; i <= 4; i++) amostra(1'b1, pat[i]);
    pos = 4;
    n_chk++;
    if (bus.travado !== 1'b1 || bus.passo !== 4'd4) begin
      $display("FAIL zeros_relock: travado=%0b passo=%0d required 1/4", bus.travado, bus.passo);
      n_fail++;
    end
  endtask

  task automatic test_habilita();
    logic [2:0] lixo [5];
    lixo = '{3'b101, 3'b000, 3'b111, 3'b010, 3'b110};
    for (int k = 0; k < 5; k++) begin
      amostra(1'b0, lixo[k]);
      n_chk++;
      if (bus.passo !== 4'd4 || bus.travado !== 1'b1 || bus.erro !== 1'b0 ||
          bus.ciclos !== 8'(exp_ciclos)) begin
        $display("FAIL hab_hold%0d: passo=%0d travado=%0b erro=%0b ciclos=%0d required 4/1/0/%0d",
                 k, bus.passo, bus.travado, bus.erro, bus.ciclos, exp_ciclos);
        n_fail++;
      end
    end
    amostra(1'b1, pat[5]);
    pos = 5;
    n_chk++;
    if (bus.passo !== 4'd5 || bus.travado !== 1'b1) begin
      $display("FAIL hab_resume: passo=%0d travado=%0b required 5/1", bus.passo, bus.travado);
      n_fail++;
    end
  endtask

  task automatic test_saturacao();
    int pulsos;
    for (int k = 0; k < 3000; k++) begin
      pos = (pos + 1) % 10;
      amostra(1'b1, pat[pos]);
      if (pos == 0 && exp_ciclos < 255) exp_ciclos++;
    end
    n_chk++;
    if (bus.ciclos !== 8'(exp_ciclos) || exp_ciclos != 255 || bus.travado !== 1'b1 ||
        bus.passo !== 4'(pos)) begin
      $display("FAIL ciclos_sat: ciclos=%0d travado=%0b passo=%0d required %0d/1/%0d",
               bus.ciclos, bus.travado, bus.passo, exp_ciclos, pos);
      n_fail++;
    end
    pulsos = 0;
    for (int j = 0; j < 260; j++) begin
      amostra(1'b1, ~pat[(pos + 1) % 10]);
      exp_erros = erros_mais_um(exp_erros);
      if (bus.erro === 1'b1) pulsos++;
      for (int i = 0; i <= 3; i++) begin
        amostra(1'b1, pat[i]);
        if (bus.erro === 1'b1) pulsos++;
      end
      pos = 3;
    end
    n_chk++;
    if (pulsos != 260) begin
      $display("FAIL erro_pulses: pulses=%0d required 260", pulsos); n_fail++;
    end
    n_chk++;
    if (bus.erros !== 8'(exp_erros) || bus.travado !== 1'b1 || bus.ciclos !== 8'd255) begin
      $display("FAIL erros_sat: erros=%0d travado=%0b ciclos=%0d required %0d/1/255",
               bus.erros, bus.travado, bus.ciclos, exp_erros);
      n_fail++;
    end
  endtask

  task automatic test_reset_travado();
    aplica_reset(1'b1, pat[4]);
    checa_reset_vals("reset_while_locked");
    amostra(1'b1, pat[0]);
    amostra(1'b1, pat[1]);
    amostra(1'b1, pat[2]);
    aplica_reset(1'b1, pat[3]);
    checa_reset_vals("reset_mid_lock");
    amostra(1'b1, pat[1]);
    n_chk++;
    if (bus.passo !== 4'd0 || bus.travado !== 1'b0) begin
      $display("FAIL reset_prev_after: passo=%0d travado=%0b required 0/0", bus.passo, bus.travado);
      n_fail++;
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    pos = 0;
    exp_ciclos = 0;
    exp_erros = 0;
    pat = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b100,
            3'b011, 3'b000, 3'b111, 3'b010, 3'b001};
    reset = 1'b1;
    bus.habilita = 1'b0;
    bus.palavras = 3'b000;
    test_reset();
    test_lock();
    test_mismatch();
    test_hold_zeros();
    test_habilita();
    test_saturacao();
    test_reset_travado();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/leitor_letreiro.md
LEITOR_LETREIRO -- requirements
Module: leitor_letreiro

Interface
REQ-001 SHALL have parameter LOCK_STEPS, default 2: consecutive matching samples after sync required to lock; legal range 1..8.
REQ-002 SHALL have parameter CICLO_W, default 8: width of the completed-cycle counter.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port habilita, input, 1 bit: sample enable; palavras is sampled only on edges where habilita=1.
REQ-006 SHALL have port palavras, input, 3 bits: sign lamp word {bar, mosca, azul}.
REQ-007 SHALL have port travado, output, 1 bit: receiver locked to the sign pattern.
REQ-008 SHALL have port passo, output, 4 bits: pattern index (0..9) of the last accepted sample; 0 when not locked or confirming.
REQ-009 SHALL have port erro, output, 1 bit: one-cycle pulse on a mismatch while locked.
REQ-010 SHALL have port ciclos, output, CICLO_W bits: completed pattern cycles while locked, saturating.
REQ-011 SHALL have port erros, output, 8 bits: mismatch count while locked, saturating (see Configuration).

Function
REQ-012 SHALL check against the fixed 10-step pattern, index 0..9: 000,100,110,111,100,011,000,111,010,001.
REQ-013 SHALL implement states BUSCA (hunt), CONFIRMA (confirm) and TRAVADO (locked); all outputs registered.
REQ-014 SHALL keep a register prev holding the last sample accepted with habilita=1.
REQ-015 BUSCA: prev=000 and sample=100 -> CONFIRMA, passo=1, confirm count=0; any other sample stays in BUSCA.
REQ-016 CONFIRMA: sample equal to pattern[(passo+1) mod 10] -> passo advances, count+1; when count reaches LOCK_STEPS -> TRAVADO on that same edge.
REQ-017 CONFIRMA: mismatch -> BUSCA, passo=0, no erro pulse, erros unchanged.
REQ-018 TRAVADO: matching sample -> passo advances with 9->0 wrap; on acceptance of step 0, ciclos increments, saturating at 2^CICLO_W-1.
REQ-019 TRAVADO: mismatch -> erro=1 for exactly the next cycle, erros+1 (saturating at 255), state BUSCA, passo=0.
REQ-020 On every accepted sample, including mismatches, prev SHALL be updated, so that a mismatching 000 followed by 100 re-syncs with no extra sample.
REQ-021 habilita=0: state, passo, prev, ciclos and erros SHALL be held, and erro SHALL be 0.
REQ-022 travado SHALL equal (state==TRAVADO) as registered after each edge.

Reset
REQ-023 reset=1 at an edge SHALL set: state BUSCA, prev=111, passo=0, travado=0, erro=0, ciclos=0, erros=0.
REQ-024 reset SHALL take priority over habilita and over any in-progress transition, including a mid-cycle lock.

Configuration
REQ-025 Macro LEITOR_LETREIRO_CONTADOR_ERROS_EN SHALL control the error counter.
REQ-026 With the macro defined, erros SHALL behave as in REQ-019.
REQ-027 Without the macro, erros SHALL be tied to 0, no counter register SHALL exist, and the erro pulse SHALL be unchanged.

Structure
REQ-028 Package leitor_letreiro_pkg SHALL hold the state enum, the constant N_PASSOS=10 and the 10-entry 3-bit pattern table constant.
REQ-029 A sub-module tabela_padrao SHALL provide the combinational lookup index -> expected word, shared with future sign blocks.

Verification
REQ-030 After reset, feed the pattern twice with habilita=1 and LOCK_STEPS=2 -> travado rises after the edge sampling 111 (step 3); ciclos=1 after the next 000; no erro.
REQ-031 While locked, replace step 5 (011) with 101 -> erro high for one cycle; erros=1; travado=0; passo=0; re-lock on the next 000->100 pair.
REQ-032 While locked at passo=3, hold 000 for 3 samples, then 100 -> erro pulse on the first 000 only; CONFIRMA entered immediately on 100.
REQ-033 While locked, drive habilita=0 for 5 cycles with garbage on palavras -> passo, ciclos and travado unchanged; erro=0.
REQ-034 Run 300 clean cycles -> ciclos saturates at 255; with the macro defined, 260 locked mismatches -> erros=255; without the macro, erros=0.
REQ-035 Assert reset together with habilita=1 while TRAVADO -> all outputs at reset values after that edge.
